gray_bin_counter_n: RTL and testbench

//  Parametrised WIDTH-bit up/down counter; output encoding selectable per cycle between

---
 rtl/gray_bin_counter_n.sv | 101 ++++++++++
 tb/tb_gray_bin_counter_n.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/gray_bin_counter_n.sv
// WIDTH-bit up/down counter with per-cycle binary/Gray output encoding, parallel load,
// wrap-or-saturate policy, and registered terminal-count and overflow flags.
module gray_bin_counter_n #(
    parameter int WIDTH = 3,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_IDX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_IDX = {WIDTH{1'b0}};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] idx_r;
    logic [WIDTH-1:0] idx_n_s;
    logic             ovf_n_s;
    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             ovf_r;

    // Next binary index and overflow: load beats enable; steps past an end wrap or block.
    always_comb begin
        idx_n_s = idx_r;
        ovf_n_s = 1'b0;
        if (load) begin
            if (mode) begin
                idx_n_s = gray2bin(load_val);
            end else begin
                idx_n_s = load_val;
            end
        end else if (en) begin
            if (dir) begin
                if (idx_r == MAX_IDX) begin
                    ovf_n_s = 1'b1;
                    if (WRAP) begin
                        idx_n_s = ZERO_IDX;
                    end else begin
                        idx_n_s = idx_r;
                    end
                end else begin
                    idx_n_s = idx_r + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                if (idx_r == ZERO_IDX) begin
                    ovf_n_s = 1'b1;
                    if (WRAP) begin
                        idx_n_s = MAX_IDX;
                    end else begin
                        idx_n_s = idx_r;
                    end
                end else begin
                    idx_n_s = idx_r - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            idx_n_s = idx_r;
        end
    end

    // State and encoded output registers; outputs reflect the index after this edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_r   <= ZERO_IDX;
            count_r <= ZERO_IDX;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            idx_r   <= idx_n_s;
            count_r <= mode ? bin2gray(idx_n_s) : idx_n_s;
            tc_r    <= dir ? (idx_n_s == MAX_IDX) : (idx_n_s == ZERO_IDX);
            ovf_r   <= ovf_n_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_gray_bin_counter_n.sv
// Scoreboard bench for gray_bin_counter_n: 3-bit wrap, 3-bit saturate and 8-bit wrap instances
// share control inputs; expected outputs are queued with the stimulus and checked by a monitor.
module tb_gray_bin_counter_n;

    logic       clk = 1'b0;
    logic       reset, en, dir, mode, load;
    logic [2:0] lv3;
    logic [7:0] lv8;
    logic [2:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

    always #5 clk = ~clk;

    gray_bin_counter_n #(.WIDTH(3), .WRAP(1'b1)) u_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(lv3), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));
    gray_bin_counter_n #(.WIDTH(3), .WRAP(1'b0)) u_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(lv3), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));
    gray_bin_counter_n #(.WIDTH(8), .WRAP(1'b1)) u_c (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(lv8), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));

    typedef struct packed {
        logic [1:0] dut;
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t       exp_q[$];
    string      name_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    bit         gray_run = 1'b0;
    logic [7:0] prev8 = 8'h00;

    logic [2:0] g_up [9] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    logic [2:0] g_dn [8] = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};

    task automatic drive(input logic r, input logic e, input logic d, input logic m,
                         input logic l, input logic [7:0] lv);
        @(negedge clk);
        reset = r; en = e; dir = d; mode = m; load = l;
        lv3 = lv[2:0]; lv8 = lv;
    endtask

    task automatic expect_out(input logic [1:0] dut, input logic [7:0] c, input logic t,
                              input logic o, input string nm);
        exp_t x;
        x.dut = dut; x.cnt = c; x.tc = t; x.ovf = o;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: after every edge, compare each queued expectation with the selected instance.
    always @(posedge clk) begin : monitor
        exp_t       x;
        string      nm;
        logic [7:0] act;
        logic       ta, oa;
        #1;
        while (exp_q.size() > 0) begin
            x  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (x.dut)
                2'd0:    begin act = {5'b0, cnt_a}; ta = tc_a; oa = ovf_a; end
                2'd1:    begin act = {5'b0, cnt_b}; ta = tc_b; oa = ovf_b; end
                default: begin act = cnt_c;         ta = tc_c; oa = ovf_c; end
            endcase
            n_chk++;
            if ({act, ta, oa} === {x.cnt, x.tc, x.ovf}) begin
                n_pass++;
            end else begin
                $display("FAIL %s dut%0d: got count=%h tc=%b ovf=%b, expected count=%h tc=%b ovf=%b",
                         nm, x.dut, act, ta, oa, x.cnt, x.tc, x.ovf);
            end
        end
        if (gray_run) begin
            n_chk++;
            if ($countones(cnt_c ^ prev8) == 1) begin
                n_pass++;
            end else begin
                $display("FAIL gray_onebit: got %h after %h, expected exactly 1 bit change", cnt_c, prev8);
            end
        end
        prev8 = cnt_c;
    end

    initial begin
        reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
        lv3 = 3'b000; lv8 = 8'h00;

        // Reset, then Gray count up through the wrap
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05); expect_out(2'd0, 8'h00, 1'b0, 1'b0, "rst_a");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); expect_out(2'd2, 8'h00, 1'b0, 1'b0, "rst_c");
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            expect_out(2'd0, {5'b0, g_up[i]}, (i == 6), (i == 7), "t1_gray_up");
        end

        // Down to zero, then Gray count down through the wrap
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00); expect_out(2'd0, 8'h00, 1'b1, 1'b0, "t2_to_zero");
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            expect_out(2'd0, {5'b0, g_dn[i]}, (i == 7), (i == 0), "t2_gray_dn");
        end

        // Binary load near top, wrap vs saturate at both ends
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06);
        expect_out(2'd0, 8'h06, 1'b0, 1'b0, "t3_load_a"); expect_out(2'd1, 8'h06, 1'b0, 1'b0, "t3_load_b");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out(2'd0, 8'h07, 1'b1, 1'b0, "t3_max_a"); expect_out(2'd1, 8'h07, 1'b1, 1'b0, "t3_max_b");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out(2'd0, 8'h00, 1'b0, 1'b1, "t3_wrap_a"); expect_out(2'd1, 8'h07, 1'b1, 1'b1, "t3_sat_b");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        expect_out(2'd0, 8'h01, 1'b0, 1'b0, "t3_load1_a"); expect_out(2'd1, 8'h01, 1'b0, 1'b0, "t3_load1_b");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out(2'd0, 8'h00, 1'b1, 1'b0, "t3_zero_a"); expect_out(2'd1, 8'h00, 1'b1, 1'b0, "t3_zero_b");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out(2'd0, 8'h07, 1'b0, 1'b1, "t3_uwrap_a"); expect_out(2'd1, 8'h00, 1'b1, 1'b1, "t3_usat_b");

        // Gray load, step, then re-encode to binary without moving
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h06); expect_out(2'd0, 8'h06, 1'b0, 1'b0, "t4_gload");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00); expect_out(2'd0, 8'h07, 1'b0, 1'b0, "t4_gstep");
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); expect_out(2'd0, 8'h05, 1'b0, 1'b0, "t4_reenc");

        // Load beats enable; reset beats load; dir alone moves tc; resume after reset
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02); expect_out(2'd0, 8'h02, 1'b0, 1'b0, "t5_load_en");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05); expect_out(2'd0, 8'h00, 1'b0, 1'b0, "t5_rst_load");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00); expect_out(2'd0, 8'h00, 1'b1, 1'b0, "t5_dir_tc");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); expect_out(2'd0, 8'h01, 1'b0, 1'b0, "t5_resume");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); expect_out(2'd0, 8'h00, 1'b0, 1'b0, "t5_rst_mid");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); expect_out(2'd0, 8'h01, 1'b0, 1'b0, "t5_resume2");

        // 8-bit binary wrap at the top
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE); expect_out(2'd2, 8'hFE, 1'b0, 1'b0, "t6_load");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); expect_out(2'd2, 8'hFF, 1'b1, 1'b0, "t6_max");
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00); expect_out(2'd2, 8'h00, 1'b0, 1'b1, "t6_wrap");

        // 8-bit full Gray cycle
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00); expect_out(2'd2, 8'h00, 1'b0, 1'b0, "t6_gload");
        for (int i = 1; i <= 256; i++) begin
            logic [7:0] n;
            n = i[7:0];
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            gray_run = 1'b1;
            expect_out(2'd2, n ^ (n >> 1), (n == 8'hFF), (n == 8'h00), "t6_gray");
        end
        @(negedge clk);
        gray_run = 1'b0;
        en = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
